// File: rtl/y86_regs_pkg.sv
// Shared definitions for the SEQ register-stack sequencer: register index type,
// the "no register" index and the sequencer state encoding.
package y86_regs_pkg;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t RNONE = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WR_E,
        WR_M,
        RD_A,
        RD_B,
        DONE
    } rps_state_t;

endpackage

// File: rtl/reg_port_sequencer_if.sv
// Core-side request/response signals plus the single shared register-stack port,
// bundled so the sequencer and its surroundings see one connection.
interface reg_port_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_dstE;
    logic [ADDR_W-1:0] wb_dstM;
    logic [DATA_W-1:0] wb_valE;
    logic [DATA_W-1:0] wb_valM;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_srcA;
    logic [ADDR_W-1:0] rd_srcB;
    logic              rd_done;
    logic [DATA_W-1:0] rd_valA;
    logic [DATA_W-1:0] rd_valB;

    logic              rf_read;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    // The sequencer side: consumes requests and stack read data, drives the port.
    modport slave (
        input  wb_valid, wb_dstE, wb_dstM, wb_valE, wb_valM,
        input  rd_valid, rd_srcA, rd_srcB,
        input  rf_rdata,
        output wb_ready, rd_ready, rd_done, rd_valA, rd_valB,
        output rf_read, rf_addr, rf_wdata
    );

    modport master (
        output wb_valid, wb_dstE, wb_dstM, wb_valE, wb_valM,
        output rd_valid, rd_srcA, rd_srcB,
        output rf_rdata,
        input  wb_ready, rd_ready, rd_done, rd_valA, rd_valB,
        input  rf_read, rf_addr, rf_wdata
    );

endinterface

// File: rtl/reg_port_sequencer.sv
// Serialises writeback (E then M) and decode (A then B) requests onto the
// single-port register stack, one access per clock, skipping RNONE indices.
module reg_port_sequencer #(
    parameter int                DATA_W = 64,
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] RNONE  = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_port_sequencer_if.slave bus
);

    import y86_regs_pkg::*;

    rps_state_t        state_q, state_d;
    logic [ADDR_W-1:0] dstE_q, dstM_q, srcA_q, srcB_q;
    logic [DATA_W-1:0] valE_q, valM_q;
    logic [DATA_W-1:0] tmpA_q, valA_q, valB_q;
    logic              wbAccept, rdAccept;

    // Writeback wins when both requests are presented in IDLE.
    assign wbAccept = (state_q == IDLE) && bus.wb_valid;
    assign rdAccept = (state_q == IDLE) && bus.rd_valid && !bus.wb_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.wb_valid) begin
                    if (bus.wb_dstE != RNONE)      state_d = WR_E;
                    else if (bus.wb_dstM != RNONE) state_d = WR_M;
                    else                           state_d = IDLE;
                end else if (bus.rd_valid) begin
                    if (bus.rd_srcA != RNONE)      state_d = RD_A;
                    else if (bus.rd_srcB != RNONE) state_d = RD_B;
                    else                           state_d = DONE;
                end
            end
            WR_E:    state_d = (dstM_q != RNONE) ? WR_M : IDLE;
            WR_M:    state_d = IDLE;
            RD_A:    state_d = (srcB_q != RNONE) ? RD_B : DONE;
            RD_B:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port and handshake outputs depend only on registered state, except the
    // IDLE rd_ready term, which must yield to a simultaneous writeback.
    always_comb begin
        bus.rf_read  = 1'b1;
        bus.rf_addr  = RNONE;
        bus.rf_wdata = '0;
        bus.wb_ready = 1'b0;
        bus.rd_ready = 1'b0;
        bus.rd_done  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.wb_ready = 1'b1;
                bus.rd_ready = !bus.wb_valid;
            end
            WR_E: begin
                bus.rf_read  = 1'b0;
                bus.rf_addr  = dstE_q;
                bus.rf_wdata = valE_q;
            end
            WR_M: begin
                bus.rf_read  = 1'b0;
                bus.rf_addr  = dstM_q;
                bus.rf_wdata = valM_q;
            end
            RD_A:    bus.rf_addr = srcA_q;
            RD_B:    bus.rf_addr = srcB_q;
            DONE:    bus.rd_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.rd_valA = valA_q;
    assign bus.rd_valB = valB_q;

    // Results land in valA/valB only on entry to DONE so they stay stable until
    // the next done pulse; tmpA_q parks srcA's data while srcB is being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dstE_q  <= '0;
            dstM_q  <= '0;
            valE_q  <= '0;
            valM_q  <= '0;
            srcA_q  <= '0;
            srcB_q  <= '0;
            tmpA_q  <= '0;
            valA_q  <= '0;
            valB_q  <= '0;
        end else begin
            state_q <= state_d;
            if (wbAccept) begin
                dstE_q <= bus.wb_dstE;
                dstM_q <= bus.wb_dstM;
                valE_q <= bus.wb_valE;
                valM_q <= bus.wb_valM;
            end
            if (rdAccept) begin
                srcA_q <= bus.rd_srcA;
                srcB_q <= bus.rd_srcB;
                tmpA_q <= '0;
            end
            if (state_q == RD_A) begin
                tmpA_q <= bus.rf_rdata;
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                valA_q <= (state_q == RD_A) ? bus.rf_rdata :
                          (state_q == RD_B) ? tmpA_q : '0;
                valB_q <= (state_q == RD_B) ? bus.rf_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed bench for reg_port_sequencer: a behavioural register stack answers the
// port, and each scenario task checks its own hand-computed expectations.
module tb_reg_port_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_port_sequencer_if bus ();

    reg_port_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] stack [16];
    assign bus.rf_rdata = stack[bus.rf_addr];

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          doneCount   = 0;
    int          writeCycles = 0;
    logic [3:0]  wrAddrLog [$];
    logic [63:0] wrDataLog [$];

    // Behavioural stack: commits a write at the end of every rf_read=0 cycle.
    always @(posedge clk) begin
        if (rst_n && !bus.rf_read) begin
            stack[bus.rf_addr] = bus.rf_wdata;
            wrAddrLog.push_back(bus.rf_addr);
            wrDataLog.push_back(bus.rf_wdata);
            writeCycles++;
        end
        if (rst_n && bus.rd_done) doneCount++;
    end

    task automatic idleInputs();
        bus.wb_valid = 1'b0;
        bus.wb_dstE  = 4'h0;
        bus.wb_dstM  = 4'h0;
        bus.wb_valE  = '0;
        bus.wb_valM  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_srcA  = 4'h0;
        bus.rd_srcB  = 4'h0;
    endtask

    // Presents a writeback and returns #1 after the accepting edge.
    task automatic sendWrite(input logic [3:0] e, input logic [3:0] m,
                             input logic [63:0] ve, input logic [63:0] vm,
                             output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_dstE  = e;
        bus.wb_dstM  = m;
        bus.wb_valE  = ve;
        bus.wb_valM  = vm;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.wb_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.wb_valid = 1'b0;
        bus.wb_dstE  = 4'h0;
        bus.wb_dstM  = 4'h0;
        bus.wb_valE  = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.wb_valM  = 64'hBAD1_BAD1_BAD1_BAD1;
    endtask

    task automatic sendRead(input logic [3:0] a, input logic [3:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_srcA  = a;
        bus.rd_srcB  = b;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.rd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.rd_valid = 1'b0;
        bus.rd_srcA  = 4'h0;
        bus.rd_srcB  = 4'h0;
    endtask

    // Counts negedges after the accept until rd_done is seen.
    task automatic waitDone(input int maxCycles, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.rd_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int doneBefore, wcBefore;
        rst_n = 1'b0;
        idleInputs();
        repeat (3) @(negedge clk);
        testsRun++;
        if (bus.rf_read !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_rf_read: got %0b expected 1", bus.rf_read); end
        testsRun++;
        if (bus.rf_addr !== 4'hF) begin testsFailed++; $display("[TB] FAIL reset_rf_addr: got %0h expected f", bus.rf_addr); end
        testsRun++;
        if (bus.rf_wdata !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_rf_wdata: got %0h expected 0", bus.rf_wdata); end
        testsRun++;
        if ({bus.rd_done, bus.wb_ready, bus.rd_ready} !== 3'b011) begin testsFailed++; $display("[TB] FAIL reset_handshake: got done/wbr/rdr=%03b expected 011", {bus.rd_done, bus.wb_ready, bus.rd_ready}); end
        testsRun++;
        if ({bus.rd_valA, bus.rd_valB} !== 128'h0) begin testsFailed++; $display("[TB] FAIL reset_vals: got %0h/%0h expected 0/0", bus.rd_valA, bus.rd_valB); end
        rst_n = 1'b1;

        stack[5] = 64'h55;
        sendRead(4'h5, 4'h6, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_read_accept: got %0b expected 1", ok); end
        doneBefore = doneCount;
        @(negedge clk);
        testsRun++;
        if (bus.rf_addr !== 4'h5) begin testsFailed++; $display("[TB] FAIL reset_in_rd_a: got addr %0h expected 5", bus.rf_addr); end
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({bus.rf_read, bus.rf_addr, bus.wb_ready} !== {1'b1, 4'hF, 1'b1}) begin testsFailed++; $display("[TB] FAIL reset_mid_read: got read/addr/wbr=%0b/%0h/%0b expected 1/f/1", bus.rf_read, bus.rf_addr, bus.wb_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        testsRun++;
        if (doneCount !== doneBefore) begin testsFailed++; $display("[TB] FAIL reset_no_done: got %0d pulses expected 0", doneCount - doneBefore); end
        testsRun++;
        if (bus.rd_valA !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_valA_kept: got %0h expected 0", bus.rd_valA); end

        wcBefore = writeCycles;
        sendWrite(4'h7, 4'h8, 64'h77, 64'h88, ok);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (bus.rf_read !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_mid_write_read: got %0b expected 1", bus.rf_read); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        testsRun++;
        if (writeCycles !== wcBefore) begin testsFailed++; $display("[TB] FAIL reset_write_lost: got %0d writes expected 0", writeCycles - wcBefore); end
    endtask

    task automatic test_write_read();
        bit ok;
        int wc, cyc;
        wc = writeCycles;
        sendWrite(4'h2, 4'hF, 64'h1111, 64'h0, ok);
        testsRun++;
        if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_accept: got %0b expected 1", ok); end
        @(negedge clk);
        testsRun++;
        if ({bus.rf_read, bus.rf_addr, bus.rf_wdata, bus.wb_ready} !== {1'b0, 4'h2, 64'h1111, 1'b0}) begin testsFailed++; $display("[TB] FAIL wr_e_port: got read/addr/data/wbr=%0b/%0h/%0h/%0b expected 0/2/1111/0", bus.rf_read, bus.rf_addr, bus.rf_wdata, bus.wb_ready); end
        @(negedge clk);
        testsRun++;
        if ({bus.rf_read, bus.wb_ready} !== 2'b11) begin testsFailed++; $display("[TB] FAIL wr_back_idle: got read/wbr=%0b/%0b expected 1/1", bus.rf_read, bus.wb_ready); end
        testsRun++;
        if (writeCycles - wc !== 1) begin testsFailed++; $display("[TB] FAIL wr_count: got %0d expected 1", writeCycles - wc); end
        testsRun++;
        if (stack[2] !== 64'h1111) begin testsFailed++; $display("[TB] FAIL wr_stack: got %0h expected 1111", stack[2]); end

        sendRead(4'h2, 4'hF, ok);
        waitDone(10, cyc, ok);
        testsRun++;
        if ({ok, cyc} !== {1'b1, 32'd2}) begin testsFailed++; $display("[TB] FAIL rd_latency: got ok=%0b cycles=%0d expected ok=1 cycles=2", ok, cyc); end
        testsRun++;
        if ({bus.rd_valA, bus.rd_valB} !== {64'h1111, 64'h0}) begin testsFailed++; $display("[TB] FAIL rd_vals: got %0h/%0h expected 1111/0", bus.rd_valA, bus.rd_valB); end
        @(negedge clk);
        testsRun++;
        if ({bus.rd_done, bus.rd_valA} !== {1'b0, 64'h1111}) begin testsFailed++; $display("[TB] FAIL rd_pulse_hold: got done=%0b valA=%0h expected 0/1111", bus.rd_done, bus.rd_valA); end
    endtask

    task automatic test_dual_write();
        bit ok;
        int wc, cyc, n;
        wc = writeCycles;
        sendWrite(4'h4, 4'h4, 64'hAA, 64'hBB, ok);
        repeat (3) @(negedge clk);
        n = wrAddrLog.size();
        testsRun++;
        if (writeCycles - wc !== 2) begin testsFailed++; $display("[TB] FAIL dual_count: got %0d expected 2", writeCycles - wc); end
        else begin
            testsRun++;
            if ({wrAddrLog[n-2], wrDataLog[n-2], wrAddrLog[n-1], wrDataLog[n-1]} !== {4'h4, 64'hAA, 4'h4, 64'hBB}) begin
                testsFailed++;
                $display("[TB] FAIL dual_order: got %0h:%0h then %0h:%0h expected 4:aa then 4:bb", wrAddrLog[n-2], wrDataLog[n-2], wrAddrLog[n-1], wrDataLog[n-1]);
            end
        end
        sendRead(4'h4, 4'hF, ok);
        waitDone(10, cyc, ok);
        testsRun++;
        if ({ok, bus.rd_valA} !== {1'b1, 64'hBB}) begin testsFailed++; $display("[TB] FAIL dual_readback: got ok=%0b valA=%0h expected 1/bb", ok, bus.rd_valA); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int cyc;
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_dstE  = 4'h9;
        bus.wb_dstM  = 4'hF;
        bus.wb_valE  = 64'h9999;
        bus.rd_valid = 1'b1;
        bus.rd_srcA  = 4'h9;
        bus.rd_srcB  = 4'hF;
        #1;
        testsRun++;
        if ({bus.wb_ready, bus.rd_ready} !== 2'b10) begin testsFailed++; $display("[TB] FAIL simul_ready: got wbr/rdr=%0b/%0b expected 1/0", bus.wb_ready, bus.rd_ready); end
        @(posedge clk);
        #1;
        bus.wb_valid = 1'b0;
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.rd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        testsRun++;
        if ({ok, cyc} !== {1'b1, 32'd2}) begin testsFailed++; $display("[TB] FAIL simul_rd_wait: got ok=%0b cycles=%0d expected 1/2", ok, cyc); end
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        waitDone(10, cyc, ok);
        testsRun++;
        if ({ok, bus.rd_valA, bus.rd_valB} !== {1'b1, 64'h9999, 64'h0}) begin testsFailed++; $display("[TB] FAIL simul_data: got ok=%0b vals=%0h/%0h expected 1 9999/0", ok, bus.rd_valA, bus.rd_valB); end
    endtask

    task automatic test_all_rnone();
        bit ok;
        int wc, cyc;
        wc = writeCycles;
        sendWrite(4'hF, 4'hF, 64'h1234, 64'h5678, ok);
        testsRun++;
        if ({ok, bus.wb_ready, bus.rf_read} !== 3'b111) begin testsFailed++; $display("[TB] FAIL none_wr_ready: got ok/wbr/read=%0b/%0b/%0b expected 1/1/1", ok, bus.wb_ready, bus.rf_read); end
        repeat (2) @(negedge clk);
        testsRun++;
        if (writeCycles !== wc) begin testsFailed++; $display("[TB] FAIL none_wr_count: got %0d expected 0", writeCycles - wc); end
        sendRead(4'hF, 4'hF, ok);
        waitDone(10, cyc, ok);
        testsRun++;
        if ({ok, cyc} !== {1'b1, 32'd1}) begin testsFailed++; $display("[TB] FAIL none_rd_latency: got ok=%0b cycles=%0d expected 1/1", ok, cyc); end
        testsRun++;
        if ({bus.rd_valA, bus.rd_valB} !== 128'h0) begin testsFailed++; $display("[TB] FAIL none_rd_vals: got %0h/%0h expected 0/0", bus.rd_valA, bus.rd_valB); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        logic [3:0] addrSeq [3];
        logic [2:0] readSeq, doneSeq;
        stack[1] = 64'h10;
        stack[3] = 64'h30;
        sendRead(4'h1, 4'h3, ok);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            addrSeq[k] = bus.rf_addr;
            readSeq[k] = bus.rf_read;
            doneSeq[k] = bus.rd_done;
        end
        testsRun++;
        if ({addrSeq[0], addrSeq[1], addrSeq[2]} !== 12'h13F) begin testsFailed++; $display("[TB] FAIL b2b_addr_seq: got %0h,%0h,%0h expected 1,3,f", addrSeq[0], addrSeq[1], addrSeq[2]); end
        testsRun++;
        if ({readSeq, doneSeq} !== {3'b111, 3'b100}) begin testsFailed++; $display("[TB] FAIL b2b_read_done: got read=%03b done=%03b expected 111/100", readSeq, doneSeq); end
        testsRun++;
        if ({bus.rd_valA, bus.rd_valB} !== {64'h10, 64'h30}) begin testsFailed++; $display("[TB] FAIL b2b_vals1: got %0h/%0h expected 10/30", bus.rd_valA, bus.rd_valB); end
        sendRead(4'h3, 4'h1, ok);
        waitDone(10, cyc, ok);
        testsRun++;
        if ({ok, cyc, bus.rd_valA, bus.rd_valB} !== {1'b1, 32'd3, 64'h30, 64'h10}) begin testsFailed++; $display("[TB] FAIL b2b_vals2: got ok=%0b cycles=%0d vals=%0h/%0h expected 1 3 30/10", ok, cyc, bus.rd_valA, bus.rd_valB); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) stack[i] = 64'hDEAD_0000 + 64'(i);
        idleInputs();
        test_reset();
        test_write_read();
        test_dual_write();
        test_simultaneous();
        test_all_rnone();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
